cylon_mode_ctrl: RTL and testbench

//   Front-end controller for the cylon LED engine. Synchronises and debounces
//   the three push-buttons, runs the mode state machine, and optionally cycles

---
 rtl/cylon_pkg.sv | 23 ++
 rtl/cylon_mode_ctrl_if.sv | 17 +
 rtl/cylon_debounce.sv | 36 +++
 rtl/cylon_mode_ctrl.sv | 69 ++++++
 tb/tb_cylon_mode_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/cylon_pkg.sv
// Shared definitions for the cylon LED engine, its mode controller and the top level.
package cylon_pkg;
  localparam int MODE_W  = 2;
  localparam int NUM_BTN = 3;
  localparam int BTN_C   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_R   = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_CYLON  = 2'b00,
    MODE_R_TO_L = 2'b01,
    MODE_L_TO_R = 2'b10
  } mode_e;

  // Demo-mode rotation order.
  function automatic mode_e mode_advance(mode_e m);
    case (m)
      MODE_CYLON:  return MODE_R_TO_L;
      MODE_R_TO_L: return MODE_L_TO_R;
      default:     return MODE_CYLON;
    endcase
  endfunction
endpackage

// File: rtl/cylon_mode_ctrl_if.sv
// Button/switch inputs and mode/speed outputs of the cylon mode controller.
interface cylon_mode_ctrl_if;
  import cylon_pkg::*;
  logic              btnC;
  logic              btnL;
  logic              btnR;
  logic              auto_en;
  logic [2:0]        speed_sw;
  logic [MODE_W-1:0] mode;
  logic [2:0]        speed;
  logic              mode_load;

  modport master (output btnC, btnL, btnR, auto_en, speed_sw,
                  input  mode, speed, mode_load);
  modport slave  (input  btnC, btnL, btnR, auto_en, speed_sw,
                  output mode, speed, mode_load);
endinterface

// File: rtl/cylon_debounce.sv
// One push-button: 2-flop sync, stability counter, one-cycle pulse on accepted press.
module cylon_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  logic        s1, s2, level;
  logic [19:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
        // Level flips; only a 0->1 flip is a press.
        level <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end
endmodule

// File: rtl/cylon_mode_ctrl.sv
// Mode controller: debounced buttons select mode, optional auto-cycling, synced speed.
module cylon_mode_ctrl
  import cylon_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [31:0] AUTO_CYCLES     = 32'd500_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  cylon_mode_ctrl_if.slave   bus
);
  logic [NUM_BTN-1:0] raw, press;
  logic               auto_s1, auto_s2;
  logic [2:0]         spd_s1, spd_s2;
  mode_e              mode_q, mode_d;
  logic [31:0]        timer_q, timer_d;
  logic               load_q;

  assign raw = {bus.btnR, bus.btnL, bus.btnC};

  cylon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
      spd_s1  <= '0;
      spd_s2  <= '0;
      mode_q  <= MODE_CYLON;
      timer_q <= '0;
      load_q  <= 1'b0;
    end else begin
      auto_s1 <= bus.auto_en;
      auto_s2 <= auto_s1;
      spd_s1  <= bus.speed_sw;
      spd_s2  <= spd_s1;
      mode_q  <= mode_d;
      timer_q <= timer_d;
      load_q  <= (mode_d != mode_q);
    end
  end

  always_comb begin
    mode_d  = mode_q;
    timer_d = timer_q;
    if (!auto_s2) begin
      timer_d = '0;
    end else if (timer_q == AUTO_CYCLES - 32'd1) begin
      timer_d = '0;
      mode_d  = mode_advance(mode_q);
    end else begin
      timer_d = timer_q + 32'd1;
    end
    // Presses override a same-cycle auto advance and restart the demo timer.
    if (|press) timer_d = '0;
    if (press[BTN_C])      mode_d = MODE_CYLON;
    else if (press[BTN_R]) mode_d = MODE_L_TO_R;
    else if (press[BTN_L]) mode_d = MODE_R_TO_L;
  end

  assign bus.mode      = mode_q;
  assign bus.speed     = spd_s2;
  assign bus.mode_load = load_q;
endmodule

// File: tb/tb_cylon_mode_ctrl.sv
// Scoreboard bench for cylon_mode_ctrl with short debounce/auto periods.
module tb_cylon_mode_ctrl;
  import cylon_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cylon_mode_ctrl_if bus ();

  cylon_mode_ctrl #(.DEBOUNCE_CYCLES(20'd4), .AUTO_CYCLES(32'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       mode_q[$];
  exp_t       spd_q[$];
  exp_t       e;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] prev_mode = 2'b00;
  logic [2:0] prev_spd = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_mode(input int lat, input mode_e m);
    mode_q.push_back('{cyc + lat, {1'b0, m}});
  endtask

  // Monitor: every mode_load pulse and every speed change must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mode_load) begin
        if (mode_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_load: mode=%0d at cycle %0d, expected no pulse", bus.mode, cyc);
        end else begin
          e = mode_q.pop_front();
          vectors++;
          if (bus.mode !== e.val[1:0] || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL mode_update: got mode=%0d at cycle %0d expected mode=%0d at cycle %0d",
                     bus.mode, cyc, e.val[1:0], e.cyc);
          end
        end
      end
      if (bus.mode !== prev_mode && !bus.mode_load) begin
        miscompares++;
        $display("FAIL silent_mode_change: got mode=%0d expected %0d (no load pulse)", bus.mode, prev_mode);
      end
      if (bus.speed !== prev_spd) begin
        if (spd_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_speed: got %0d at cycle %0d expected %0d", bus.speed, cyc, prev_spd);
        end else begin
          e = spd_q.pop_front();
          vectors++;
          if (bus.speed !== e.val || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL speed_update: got speed=%0d at cycle %0d expected speed=%0d at cycle %0d",
                     bus.speed, cyc, e.val, e.cyc);
          end
        end
      end
    end
    prev_mode = bus.mode;
    prev_spd  = bus.speed;
  end

  initial begin
    bus.btnC = 1'b1; bus.btnL = 1'b1; bus.btnR = 1'b1;
    bus.auto_en = 1'b1; bus.speed_sw = 3'b111;
    rst_n = 1'b0;

    // Reset with all inputs high.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_mode", 32'(bus.mode), 32'd0);
      check("rst_speed", 32'(bus.speed), 32'd0);
      check("rst_load", 32'(bus.mode_load), 32'd0);
    end
    rst_n = 1'b1;
    bus.btnL = 1'b0; bus.btnR = 1'b0; bus.auto_en = 1'b0; bus.speed_sw = 3'b000;
    tick(12);
    check("held_btnC_mode", 32'(bus.mode), 32'(MODE_CYLON));
    bus.btnC = 1'b0;
    tick(10);

    // Debounced press of L, then a short glitch on R.
    bus.btnL = 1'b1; push_mode(7, MODE_R_TO_L);
    tick(6); bus.btnL = 1'b0;
    tick(10);
    bus.btnR = 1'b1; tick(3); bus.btnR = 1'b0;
    tick(10);
    check("glitch_mode", 32'(bus.mode), 32'(MODE_R_TO_L));

    // Simultaneous presses: C wins; then R alone.
    bus.btnC = 1'b1; bus.btnL = 1'b1; bus.btnR = 1'b1; push_mode(7, MODE_CYLON);
    tick(8);
    bus.btnC = 1'b0; bus.btnL = 1'b0; bus.btnR = 1'b0;
    tick(10);
    bus.btnR = 1'b1; push_mode(7, MODE_L_TO_R);
    tick(8); bus.btnR = 1'b0;
    tick(10);

    // Back to CYLON, then auto-cycle three steps and freeze.
    bus.btnC = 1'b1; push_mode(7, MODE_CYLON);
    tick(8); bus.btnC = 1'b0;
    tick(10);
    bus.auto_en = 1'b1;
    push_mode(18, MODE_R_TO_L);
    push_mode(34, MODE_L_TO_R);
    push_mode(50, MODE_CYLON);
    tick(52);
    bus.auto_en = 1'b0;
    tick(40);
    check("auto_frozen_mode", 32'(bus.mode), 32'(MODE_CYLON));

    // Press during auto restarts the timer.
    bus.auto_en = 1'b1;
    tick(6);
    bus.btnR = 1'b1;
    push_mode(7, MODE_L_TO_R);
    push_mode(23, MODE_CYLON);
    tick(8); bus.btnR = 1'b0;
    tick(16);
    bus.auto_en = 1'b0;
    tick(20);

    // Speed path.
    bus.speed_sw = 3'b101;
    spd_q.push_back('{cyc + 2, 3'd5});
    tick(5);
    check("speed_mode", 32'(bus.mode), 32'(MODE_CYLON));
    tick(3);

    while (mode_q.size() > 0) begin
      e = mode_q.pop_front();
      miscompares++;
      $display("FAIL missing_load: got no pulse expected mode=%0d at cycle %0d", e.val[1:0], e.cyc);
    end
    while (spd_q.size() > 0) begin
      e = spd_q.pop_front();
      miscompares++;
      $display("FAIL missing_speed: got no change expected speed=%0d at cycle %0d", e.val, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
